// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: 2-flop synchronized rxd, mid-bit sampling, CPB latched per frame.
// Optional parity stage under `UART_RX_PARITY_EN` (adds par_odd input and parity_err strobe).
module uart_rx_sampler #(
  parameter int CPB_MIN   = 26,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 s0,
  input  logic                 s1,
  input  logic                 rxd,
`ifdef UART_RX_PARITY_EN
  input  logic                 par_odd,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(8 * CPB_MIN);
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        cpb_m1_q, cpb_m1_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic [CW-1:0]        cpb_m1_sel;
  logic                 rxd_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_odd_q, par_odd_d;
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  assign rxd_s = sync2_q;

  // Held as CPB-1 so the register never needs more than the counter width.
  always_comb begin
    case ({s1, s0})
      2'b00:   cpb_m1_sel = CW'(8 * CPB_MIN - 1);
      2'b01:   cpb_m1_sel = CW'(4 * CPB_MIN - 1);
      2'b10:   cpb_m1_sel = CW'(2 * CPB_MIN - 1);
      default: cpb_m1_sel = CW'(CPB_MIN - 1);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sync1_d     = rxd;
    sync2_d     = sync1_q;
    cnt_d       = cnt_q + CW'(1);
    cpb_m1_d    = cpb_m1_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_odd_d    = par_odd_q;
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          state_d  = S_START;
          cnt_d    = '0;
          cpb_m1_d = cpb_m1_sel;
`ifdef UART_RX_PARITY_EN
          par_odd_d = par_odd;
`endif
        end
      end
      S_START: begin
        // CPB is even, so (CPB-1)>>1 equals CPB/2-1.
        if (cnt_q == (cpb_m1_q >> 1)) begin
          cnt_d   = '0;
          state_d = rxd_s ? S_IDLE : S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (cnt_q == cpb_m1_q) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxd_s;
          idx_d          = idx_q + IW'(1);
          if (idx_q == IW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == cpb_m1_q) begin
          cnt_d     = '0;
          par_bad_d = (^shift_q) ^ rxd_s ^ par_odd_q;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leaving at mid stop bit lets an immediately following start edge be caught.
        if (cnt_q == cpb_m1_q) begin
          cnt_d = '0;
          if (rxd_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxd_s) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cnt_q       <= '0;
      cpb_m1_q    <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_odd_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      cpb_m1_q    <= cpb_m1_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_odd_q    <= par_odd_d;
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: serial frames driven bit by bit, strobes collected and
// compared with bytes expected from the frame contents and the baud/latency rules.
module tb_uart_rx_sampler;
  localparam int CPB_MIN = 26;
  localparam int DB      = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       s0     = 1'b1;
  logic       s1     = 1'b1;
  logic       rxd    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       par_odd = 1'b0;
  logic       parity_err;
`endif

  uart_rx_sampler #(.CPB_MIN(CPB_MIN), .DATA_BITS(DB)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .s0        (s0),
    .s1        (s1),
    .rxd       (rxd),
`ifdef UART_RX_PARITY_EN
    .par_odd   (par_odd),
    .parity_err(parity_err),
`endif
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_fail = 0;
  int pos_cyc = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int hold_bad = 0;
  int seen = 0;
  int last_start = 0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] last_good = 8'h00;
  logic [7:0] val_dat[$];
  int         val_cyc[$];
  logic       val_perr[$];
  logic [7:0] exp_dat[$];
  logic       exp_perr[$];
  int         mult[4] = '{8, 4, 2, 1};

  always @(posedge clk_in) pos_cyc <= pos_cyc + 1;

  always @(negedge clk_in) begin
    if (rx_valid) begin
      val_dat.push_back(rx_data);
      val_cyc.push_back(pos_cyc);
`ifdef UART_RX_PARITY_EN
      val_perr.push_back(parity_err);
`else
      val_perr.push_back(1'b0);
`endif
    end
    if (frame_err) ferr_cnt++;
    if (rx_valid && frame_err) both_cnt++;
    if (rst_n && !rx_valid && rx_data !== prev_data) hold_bad++;
    prev_data = rx_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full frame: start, data LSB first, optional parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] sel, input logic stop_b,
                            input bit scramble, input bit flip);
    int cpb;
    int nb;
    logic [11:0] bits;
    cpb = CPB_MIN * mult[sel];
    {s1, s0} = sel;
    bits = '0;
    for (int i = 0; i < DB; i++) bits[1 + i] = d[i];
    nb = DB + 1;
`ifdef UART_RX_PARITY_EN
    bits[nb] = (^d) ^ par_odd ^ flip;
    nb++;
`endif
    bits[nb] = stop_b;
    nb++;
    for (int i = 0; i < nb; i++) begin
      rxd = bits[i];
      if (i == 0) last_start = pos_cyc;
      if (scramble && i == 3) {s1, s0} = 2'($urandom);
      repeat (cpb) @(negedge clk_in);
    end
    if (stop_b) begin
      exp_dat.push_back(d);
      exp_perr.push_back(flip);
    end
  endtask

  task automatic drain(input string tag);
    int n_got;
    n_got = val_dat.size() - seen;
    check({tag, "_cnt"}, n_got, exp_dat.size());
    for (int i = 0; i < exp_dat.size() && i < n_got; i++) begin
      check({tag, "_dat"}, val_dat[seen + i], exp_dat[i]);
`ifdef UART_RX_PARITY_EN
      check({tag, "_perr"}, val_perr[seen + i], exp_perr[i]);
`endif
    end
    if (exp_dat.size() > 0) last_good = exp_dat[exp_dat.size() - 1];
    seen = val_dat.size();
    exp_dat.delete();
    exp_perr.delete();
  endtask

  initial begin
    int ferr0;
    int lat;
    logic [7:0] d;
    logic [1:0] sel;

    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    repeat (1000) @(negedge clk_in);
    check("idle_strobes", val_dat.size(), 0);
    check("idle_ferr", ferr_cnt, 0);
    check("idle_busy", busy, 1'b0);

    send_frame(8'hA5, 2'b11, 1'b1, 1'b0, 1'b0);
    repeat (40) @(negedge clk_in);
    lat = (val_dat.size() > seen) ? val_cyc[seen] - last_start : -1;
    check("fast_latency", lat, 2 + CPB_MIN / 2 + (DB + 1 + PB) * CPB_MIN + 1);
    drain("fast");
    check("fast_ferr", ferr_cnt, 0);

    for (int s = 0; s < 4; s++) begin
      send_frame(8'h3C, 2'(s), 1'b1, 1'b1, 1'b0);
      send_frame(8'hC3, 2'(s), 1'b1, 1'b1, 1'b0);
      rxd = 1'b1;
      repeat (30) @(negedge clk_in);
      drain($sformatf("baud%0d", s));
    end

    {s1, s0} = 2'b11;
    ferr0 = ferr_cnt;
    rxd = 1'b0;
    repeat (8) @(negedge clk_in);
    rxd = 1'b1;
    repeat (60) @(negedge clk_in);
    check("glitch_busy", busy, 1'b0);
    check("glitch_ferr", ferr_cnt - ferr0, 0);
    drain("glitch");

    send_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
    repeat (500) @(negedge clk_in);
    check("brk_busy", busy, 1'b1);
    check("brk_ferr", ferr_cnt - ferr0, 1);
    check("brk_hold", rx_data, last_good);
    drain("brk");
    rxd = 1'b1;
    repeat (10) @(negedge clk_in);
    check("brk_release", busy, 1'b0);

    // Abort 0xFF partway through data bit 4.
    {s1, s0} = 2'b11;
    rxd = 1'b0;
    repeat (CPB_MIN) @(negedge clk_in);
    rxd = 1'b1;
    repeat (4 * CPB_MIN + 10) @(negedge clk_in);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    check("mrst_busy", busy, 1'b0);
    check("mrst_data", rx_data, 8'h00);
    repeat ((4 + PB) * CPB_MIN) @(negedge clk_in);
    drain("mrst");
    send_frame(8'h12, 2'b11, 1'b1, 1'b0, 1'b0);
    repeat (30) @(negedge clk_in);
    drain("mrst_next");

    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      sel = 2'($urandom_range(0, 3));
      rxd = 1'b1;
      repeat ($urandom_range(0, 30)) @(negedge clk_in);
`ifdef UART_RX_PARITY_EN
      send_frame(d, sel, 1'b1, 1'($urandom), 1'($urandom));
`else
      send_frame(d, sel, 1'b1, 1'($urandom), 1'b0);
`endif
    end
    rxd = 1'b1;
    repeat (40) @(negedge clk_in);
    drain("rand");

`ifdef UART_RX_PARITY_EN
    par_odd = 1'b0;
    send_frame(8'h07, 2'b11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h07, 2'b11, 1'b1, 1'b0, 1'b1);
    rxd = 1'b1;
    repeat (40) @(negedge clk_in);
    drain("par");
`endif

    check("no_overlap", both_cnt, 0);
    check("data_hold", hold_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
